// File: rtl/vc_dest_arbiter_if.sv
// Bundles the VC FIFO heads, the destination FIFO controls and the arbiter status.
// The master modport is the arbiter side and the slave modport is the FIFO/environment side.
interface vc_dest_arbiter_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 5
) ();
    logic [DATA_W-1:0] vc0_data;
    logic [DATA_W-1:0] vc1_data;
    logic              vc0_empty;
    logic              vc1_empty;
    logic              d0_almost_full;
    logic              d1_almost_full;
    logic              pop_vc0;
    logic              pop_vc1;
    logic              push_d0;
    logic              push_d1;
    logic [DATA_W-1:0] data_d0;
    logic [DATA_W-1:0] data_d1;
    logic [CNT_W-1:0]  cnt_d0;
    logic [CNT_W-1:0]  cnt_d1;
    logic              arb_idle;

    modport master (
        input  vc0_data, vc1_data, vc0_empty, vc1_empty, d0_almost_full, d1_almost_full,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1, cnt_d0, cnt_d1, arb_idle
    );

    modport slave (
        output vc0_data, vc1_data, vc0_empty, vc1_empty, d0_almost_full, d1_almost_full,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1, cnt_d0, cnt_d1, arb_idle
    );
endinterface

// File: rtl/vc_dest_arbiter.sv
// Two-VC to two-destination arbiter: pops one eligible VC head per cycle and pushes it to
// the destination named by bit DATA_W-2. Define ROUND_ROBIN_EN for fair grants on contention.
module vc_dest_arbiter #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    vc_dest_arbiter_if.master   bus
);
    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_STALL  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              elig0_s;
    logic              elig1_s;
    logic              pop_en_s;
    logic              gnt0_s;
    logic              gnt1_s;
    logic              pop_any_s;
    logic              pop_dest_s;
    logic [DATA_W-1:0] pop_word_s;
    logic              push_d0_r;
    logic              push_d1_r;
    logic [DATA_W-1:0] data_d0_r;
    logic [DATA_W-1:0] data_d1_r;
    logic [CNT_W-1:0]  cnt_d0_r;
    logic [CNT_W-1:0]  cnt_d1_r;
    logic              arb_idle_r;

    // Eligibility: head present and its destination has room for one more word.
    always_comb begin
        elig0_s = 1'b0;
        elig1_s = 1'b0;
        if (bus.vc0_data[DATA_W-2]) begin
            elig0_s = !bus.vc0_empty && !bus.d1_almost_full;
        end else begin
            elig0_s = !bus.vc0_empty && !bus.d0_almost_full;
        end
        if (bus.vc1_data[DATA_W-2]) begin
            elig1_s = !bus.vc1_empty && !bus.d1_almost_full;
        end else begin
            elig1_s = !bus.vc1_empty && !bus.d0_almost_full;
        end
    end

    // No pops while held in reset, flushing, or in the RESET state itself.
    assign pop_en_s = !reset && !init && (state_r != ST_RESET);

`ifdef ROUND_ROBIN_EN
    logic last_vc1_r;

    // Round-robin grant: on contention the VC that lost the previous contest wins.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (elig0_s && elig1_s) begin
            gnt0_s = pop_en_s && last_vc1_r;
            gnt1_s = pop_en_s && !last_vc1_r;
        end else begin
            gnt0_s = pop_en_s && elig0_s;
            gnt1_s = pop_en_s && elig1_s;
        end
    end

    // Remember who won the last contested cycle; starting at VC1 gives VC0 the first win.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_vc1_r <= 1'b1;
        end else if (init) begin
            last_vc1_r <= 1'b1;
        end else if (pop_en_s && elig0_s && elig1_s) begin
            last_vc1_r <= gnt1_s;
        end else begin
            last_vc1_r <= last_vc1_r;
        end
    end
`else
    // Strict priority grant: VC0 always wins when eligible.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (elig0_s) begin
            gnt0_s = pop_en_s;
        end else begin
            gnt1_s = pop_en_s && elig1_s;
        end
    end
`endif

    assign pop_any_s  = gnt0_s || gnt1_s;
    assign pop_word_s = gnt1_s ? bus.vc1_data : bus.vc0_data;
    assign pop_dest_s = pop_word_s[DATA_W-2];

    // Next-state classification from this cycle's inputs.
    always_comb begin
        state_nxt_s = ST_RESET;
        if (init) begin
            state_nxt_s = ST_RESET;
        end else begin
            case (state_r)
                ST_RESET: state_nxt_s = ST_IDLE;
                default: begin
                    if (pop_any_s) begin
                        state_nxt_s = ST_ACTIVE;
                    end else if (bus.vc0_empty && bus.vc1_empty) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_STALL;
                    end
                end
            endcase
        end
    end

    // State, push strobes, data and counters; a popped word is pushed on the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_RESET;
            arb_idle_r <= 1'b0;
            push_d0_r  <= 1'b0;
            push_d1_r  <= 1'b0;
            data_d0_r  <= {DATA_W{1'b0}};
            data_d1_r  <= {DATA_W{1'b0}};
            cnt_d0_r   <= {CNT_W{1'b0}};
            cnt_d1_r   <= {CNT_W{1'b0}};
        end else if (init) begin
            state_r    <= ST_RESET;
            arb_idle_r <= 1'b0;
            push_d0_r  <= 1'b0;
            push_d1_r  <= 1'b0;
            cnt_d0_r   <= {CNT_W{1'b0}};
            cnt_d1_r   <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            arb_idle_r <= (state_nxt_s == ST_IDLE);
            push_d0_r  <= pop_any_s && !pop_dest_s;
            push_d1_r  <= pop_any_s && pop_dest_s;
            if (pop_any_s && !pop_dest_s) begin
                data_d0_r <= pop_word_s;
                cnt_d0_r  <= cnt_d0_r + CNT_ONE;
            end else begin
                data_d0_r <= data_d0_r;
                cnt_d0_r  <= cnt_d0_r;
            end
            if (pop_any_s && pop_dest_s) begin
                data_d1_r <= pop_word_s;
                cnt_d1_r  <= cnt_d1_r + CNT_ONE;
            end else begin
                data_d1_r <= data_d1_r;
                cnt_d1_r  <= cnt_d1_r;
            end
        end
    end

    assign bus.pop_vc0  = gnt0_s;
    assign bus.pop_vc1  = gnt1_s;
    assign bus.push_d0  = push_d0_r;
    assign bus.push_d1  = push_d1_r;
    assign bus.data_d0  = data_d0_r;
    assign bus.data_d1  = data_d1_r;
    assign bus.cnt_d0   = cnt_d0_r;
    assign bus.cnt_d1   = cnt_d1_r;
    assign bus.arb_idle = arb_idle_r;
endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed self-checking bench for vc_dest_arbiter with queue-modelled show-ahead VC FIFOs.
module tb_vc_dest_arbiter;
    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_STALL  = 2'd3;

    logic clk;
    logic reset;
    logic init;
    int   checks;
    int   errors;
    logic [5:0] q0[$];
    logic [5:0] q1[$];

    vc_dest_arbiter_if #(.DATA_W(6), .CNT_W(5)) bus ();

    vc_dest_arbiter #(.DATA_W(6), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .init  (init),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        bus.vc0_empty = (q0.size() == 0);
        bus.vc1_empty = (q1.size() == 0);
        bus.vc0_data  = (q0.size() > 0) ? q0[0] : 6'h00;
        bus.vc1_data  = (q1.size() > 0) ? q1[0] : 6'h00;
        #1;
    endtask

    task automatic tick();
        logic p0;
        logic p1;
        p0 = bus.pop_vc0;
        p1 = bus.pop_vc1;
        @(posedge clk);
        #1;
        if (p0 && q0.size() > 0) void'(q0.pop_front());
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        settle();
    endtask

    task automatic do_init();
        init = 1'b1;
        #1;
        tick();
        init = 1'b0;
        settle();
    endtask

    initial begin
        logic [5:0] w;
        logic       exp_g0;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        init   = 1'b0;
        bus.d0_almost_full = 1'b0;
        bus.d1_almost_full = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            w = 6'(i);
            q0.push_back(w);
        end
        settle();

        // Reset held four cycles with VC0 loaded.
        repeat (4) tick();
        check("rst_pop_vc0", 32'(bus.pop_vc0), 32'h0);
        check("rst_push_d0", 32'(bus.push_d0), 32'h0);
        check("rst_data_d0", 32'(bus.data_d0), 32'h0);
        check("rst_cnt_d1", 32'(bus.cnt_d1), 32'h0);
        check("rst_idle", 32'(bus.arb_idle), 32'h0);
        check("rst_state", 32'(dut.state_r), 32'(ST_RESET));

        // Release: RESET -> IDLE, then VC0 drains 0x01..0x05 to D0.
        reset = 1'b0;
        settle();
        tick();
        check("rel_state", 32'(dut.state_r), 32'(ST_IDLE));
        check("rel_pop_vc0", 32'(bus.pop_vc0), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("s1_push_d0", 32'(bus.push_d0), 32'h1);
            check("s1_data_d0", 32'(bus.data_d0), 32'(i));
            check("s1_push_d1", 32'(bus.push_d1), 32'h0);
        end
        tick();
        check("s1_push_end", 32'(bus.push_d0), 32'h0);
        check("s1_data_hold", 32'(bus.data_d0), 32'h05);
        check("s1_cnt_d0", 32'(bus.cnt_d0), 32'd5);
        check("s1_idle", 32'(bus.arb_idle), 32'h1);

        // Strict priority: VC0 0x01 first, then VC1 0x31, 0x32 to D1.
        do_init();
        check("init_cnt_d0", 32'(bus.cnt_d0), 32'h0);
        tick();
        q0.push_back(6'h01);
        q1.push_back(6'h31);
        q1.push_back(6'h32);
        settle();
        check("s2_pop_vc0", 32'(bus.pop_vc0), 32'h1);
        check("s2_pop_vc1", 32'(bus.pop_vc1), 32'h0);
        tick();
        check("s2_push_d0", 32'(bus.push_d0), 32'h1);
        check("s2_data_d0", 32'(bus.data_d0), 32'h01);
        check("s2_push_d1a", 32'(bus.push_d1), 32'h0);
        tick();
        check("s2_push_d1b", 32'(bus.push_d1), 32'h1);
        check("s2_data_d1b", 32'(bus.data_d1), 32'h31);
        check("s2_push_d0b", 32'(bus.push_d0), 32'h0);
        tick();
        check("s2_data_d1c", 32'(bus.data_d1), 32'h32);
        tick();
        check("s2_cnt_d0", 32'(bus.cnt_d0), 32'd1);
        check("s2_cnt_d1", 32'(bus.cnt_d1), 32'd2);

        // Almost-full on D0 blocks VC0 head 0x02; VC1 head 0x30 still goes to D1.
        bus.d0_almost_full = 1'b1;
        q0.push_back(6'h02);
        q1.push_back(6'h30);
        settle();
        check("s3_pop_vc0", 32'(bus.pop_vc0), 32'h0);
        check("s3_pop_vc1", 32'(bus.pop_vc1), 32'h1);
        tick();
        check("s3_data_d1", 32'(bus.data_d1), 32'h30);
        tick();
        check("s3_state", 32'(dut.state_r), 32'(ST_STALL));
        check("s3_no_push", 32'(bus.push_d0), 32'h0);
        bus.d0_almost_full = 1'b0;
        settle();
        check("s3_rel_pop", 32'(bus.pop_vc0), 32'h1);
        tick();
        check("s3_push_d0", 32'(bus.push_d0), 32'h1);
        check("s3_data_d0", 32'(bus.data_d0), 32'h02);
        check("s3_active", 32'(dut.state_r), 32'(ST_ACTIVE));

        // Almost-full rising with a pop does not cancel that pop's push.
        q0.push_back(6'h03);
        q0.push_back(6'h04);
        settle();
        tick();
        bus.d0_almost_full = 1'b1;
        settle();
        check("s4_push_d0", 32'(bus.push_d0), 32'h1);
        check("s4_data_d0", 32'(bus.data_d0), 32'h03);
        check("s4_blocked", 32'(bus.pop_vc0), 32'h0);
        tick();
        check("s4_no_push", 32'(bus.push_d0), 32'h0);
        bus.d0_almost_full = 1'b0;
        settle();
        tick();
        check("s4_data_d0b", 32'(bus.data_d0), 32'h04);

        // 33 words to D1 wrap the 5-bit counter to 1.
        do_init();
        tick();
        for (int i = 0; i < 33; i++) begin
            w = 6'h10 | 6'(i % 16);
            q1.push_back(w);
        end
        settle();
        repeat (31) tick();
        check("s5_cnt_max", 32'(bus.cnt_d1), 32'd31);
        repeat (2) tick();
        check("s5_cnt_wrap", 32'(bus.cnt_d1), 32'd1);
        check("s5_cnt_d0", 32'(bus.cnt_d0), 32'd0);
        tick();

        // init pulse mid-stream.
        for (int i = 1; i <= 4; i++) begin
            w = 6'(i);
            q0.push_back(w);
        end
        settle();
        repeat (2) tick();
        check("s6_data_pre", 32'(bus.data_d0), 32'h02);
        init = 1'b1;
        settle();
        check("s6_init_pop", 32'(bus.pop_vc0), 32'h0);
        tick();
        init = 1'b0;
        settle();
        check("s6_push", 32'(bus.push_d0), 32'h0);
        check("s6_cnt_d0", 32'(bus.cnt_d0), 32'h0);
        check("s6_cnt_d1", 32'(bus.cnt_d1), 32'h0);
        check("s6_data_hold", 32'(bus.data_d0), 32'h02);
        check("s6_state", 32'(dut.state_r), 32'(ST_RESET));
        check("s6_rst_pop", 32'(bus.pop_vc0), 32'h0);
        tick();
        tick();
        check("s6_resume", 32'(bus.data_d0), 32'h03);
        check("s6_cnt_res", 32'(bus.cnt_d0), 32'd1);

        // Asynchronous reset mid-stream with 0x04 in flight.
        #1;
        reset = 1'b1;
        #1;
        check("s7_push", 32'(bus.push_d0), 32'h0);
        check("s7_data", 32'(bus.data_d0), 32'h0);
        check("s7_cnt", 32'(bus.cnt_d0), 32'h0);
        check("s7_pop", 32'(bus.pop_vc0), 32'h0);
        check("s7_idle", 32'(bus.arb_idle), 32'h0);
        tick();
        reset = 1'b0;
        settle();
        tick();
        check("s7_no_ghost", 32'(bus.push_d0), 32'h0);
        tick();
        check("s7_fresh", 32'(bus.data_d0), 32'h04);
        tick();

        // Contention with distinct destinations.
        for (int i = 1; i <= 3; i++) begin
            w = 6'(i);
            q0.push_back(w);
            w = 6'h30 | 6'(i);
            q1.push_back(w);
        end
        settle();
        for (int i = 0; i < 6; i++) begin
`ifdef ROUND_ROBIN_EN
            exp_g0 = (i % 2 == 0);
`else
            exp_g0 = (i < 3);
`endif
            check("s8_gnt_vc0", 32'(bus.pop_vc0), 32'(exp_g0));
            check("s8_gnt_vc1", 32'(bus.pop_vc1), 32'(!exp_g0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
